// File: rtl/icache.sv
// icache: direct-mapped instruction cache with zero-latency hits and a
// word-serial line refill from the memory controller.
module icache #(
    parameter int INDEX_WIDTH  = 5,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_signal,
    input  logic [31:0] fetch_addr,
    output logic        fetch_done,
    output logic [31:0] fetch_instr,
    input  logic        clear_signal,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);
    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int WORDS     = 1 << OFFSET_WIDTH;
    localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH - 2;

    typedef logic [WORDS-1:0][31:0] line_t;
    typedef enum logic {IDLE, REFILL} state_t;

    state_t                  state, next_state;
    logic [LINES-1:0]        valid;
    logic [TAG_WIDTH-1:0]    tag_mem [LINES];
    line_t                   data_mem [LINES];
    line_t                   line_buf, next_line;
    logic [TAG_WIDTH-1:0]    ref_tag;
    logic [INDEX_WIDTH-1:0]  ref_idx;
    logic [OFFSET_WIDTH-1:0] counter;

    logic [TAG_WIDTH-1:0]    f_tag;
    logic [INDEX_WIDTH-1:0]  f_idx;
    logic [OFFSET_WIDTH-1:0] f_off;
    logic                    hit;
    logic                    start_refill, word_done, last_word;

    // A flush never aborts a refill, so clear_signal has no effect here.
    logic unused_ok;
    assign unused_ok = ^{fetch_addr[1:0], clear_signal};

    assign f_off = fetch_addr[OFFSET_WIDTH+1:2];
    assign f_idx = fetch_addr[INDEX_WIDTH+OFFSET_WIDTH+1:OFFSET_WIDTH+2];
    assign f_tag = fetch_addr[31:INDEX_WIDTH+OFFSET_WIDTH+2];
    assign hit   = valid[f_idx] && (tag_mem[f_idx] == f_tag);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        next_state   = state;
        start_refill = 1'b0;
        word_done    = 1'b0;
        last_word    = 1'b0;
        fetch_done   = 1'b0;
        case (state)
            IDLE: begin
                fetch_done = fetch_signal && hit && rdy_in && rst_in;
                if (rdy_in && fetch_signal && !hit) begin
                    start_refill = 1'b1;
                    next_state   = REFILL;
                end
            end
            REFILL: begin
                word_done = rdy_in && mem_done;
                last_word = word_done && (counter == '1);
                if (last_word) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign fetch_instr = fetch_done ? data_mem[f_idx][f_off] : 32'h0;

    always_comb begin
        next_line          = line_buf;
        next_line[counter] = mem_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= next_state;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid    <= '0;
            counter  <= '0;
            mem_req  <= 1'b0;
            mem_addr <= 32'h0;
            ref_tag  <= '0;
            ref_idx  <= '0;
        end else if (start_refill) begin
            ref_tag  <= f_tag;
            ref_idx  <= f_idx;
            counter  <= '0;
            mem_req  <= 1'b1;
            mem_addr <= {f_tag, f_idx, {OFFSET_WIDTH{1'b0}}, 2'b00};
        end else if (last_word) begin
            valid[ref_idx] <= 1'b1;
            counter        <= '0;
            mem_req        <= 1'b0;
        end else if (word_done) begin
            counter  <= counter + OFFSET_WIDTH'(1);
            mem_addr <= {ref_tag, ref_idx, counter + OFFSET_WIDTH'(1), 2'b00};
        end
    end

    // NOTE: tag/data storage and the line buffer are not reset; valid bits alone gate their use.
    always_ff @(posedge clk_in) begin
        if (word_done) begin
            line_buf <= next_line;
            if (last_word) begin
                tag_mem[ref_idx]  <= ref_tag;
                data_mem[ref_idx] <= next_line;
            end
        end
    end
endmodule
